// File: rtl/sub_later_pipe_pkg.sv
// Shared constants for the sub_later_pipe slice.
// Default operand width and the matching result width.
package sub_later_pipe_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int RES_W     = WIDTH_DEF + 1;

  function automatic int res_w(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/sub_later_pipe_reg.sv
// pipe_reg: generic W-bit D register, async active-high clear.
// Ports: clk, rst_n (clear while 1), d in, q out.
module pipe_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/sub_later_pipe.sv
// Two-stage unsigned subtractor, signed WIDTH+1 result.
// Ports: clk, rst_n (async, clear while 1), aIn, bIn, subOut.
module sub_later_pipe
  import sub_later_pipe_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] aIn,
  input  logic [WIDTH-1:0] bIn,
  output logic [WIDTH:0]   subOut
);

  localparam int RW = res_w(WIDTH);

  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [RW-1:0]    sub_d, sub_q;

  // Zero-extend first so the borrow lands in the sign bit.
  always_comb begin
    a_d   = aIn;
    b_d   = bIn;
    sub_d = {1'b0, a_q} - {1'b0, b_q};
  end

  pipe_reg #(.W(WIDTH)) u_a_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (a_d),
    .q     (a_q)
  );

  pipe_reg #(.W(WIDTH)) u_b_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (b_d),
    .q     (b_q)
  );

  pipe_reg #(.W(RW)) u_sub_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sub_d),
    .q     (sub_q)
  );

  assign subOut = sub_q;

endmodule

// File: tb/tb_sub_later_pipe.sv
// Scoreboard bench for sub_later_pipe.
// Expected differences queued at drive, popped after each edge.
module tb_sub_later_pipe;

  logic       clk;
  logic       rst_n;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic [4:0] subOut;

  int errors = 0;
  int checks = 0;
  logic [4:0] sb[$];

  sub_later_pipe #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .aIn    (aIn),
    .bIn    (bIn),
    .subOut (subOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [4:0] got,
                       input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] diff(input logic [3:0] a,
                                      input logic [3:0] b);
    int d;
    d = int'(a) - int'(b);
    return 5'(d);
  endfunction

  task automatic step(input string tag,
                      input logic [3:0] a,
                      input logic [3:0] b);
    logic [4:0] exp;
    @(negedge clk);
    aIn = a;
    bIn = b;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, subOut, 5'bxxxxx);
    end else begin
      exp = sb.pop_front();
      check(tag, subOut, exp);
    end
    sb.push_back(diff(a, b));
  endtask

  task automatic release_rst();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    sb.push_back(5'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    aIn   = 4'hF;
    bIn   = 4'h0;
    #1;
    check("rst_t0", subOut, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", subOut, 5'd0);
    end

    release_rst();
    step("lat_first", 4'd5, 4'd3);
    step("plus2", 4'd3, 4'd5);
    step("minus2", 4'd0, 4'd15);
    step("minus15", 4'd15, 4'd0);
    step("plus15", 4'd7, 4'd7);
    step("stream0", 4'd9, 4'd4);
    step("stream5", 4'd1, 4'd8);
    step("stream_m7", 4'd12, 4'd12);
    step("stream_z", 4'd2, 4'd9);

    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("async_rst", subOut, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst_hold", subOut, 5'd0);
    end
    release_rst();
    step("post_rel_zero", 4'd11, 4'd2);
    step("post_rel_diff", 4'd4, 4'd13);
    step("post_rel_next", 4'd0, 4'd0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step("sweep", 4'(a), 4'(b));
      end
    end
    step("drain", 4'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
